axi_protocol_checker: RTL and testbench
=======================================

AXI_PROTOCOL_CHECKER -- requirements
Module: axi_protocol_checker

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-002 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 8, burst queue depth per direction (power of two, 2..64).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, stall limit (>=2).
REQ-005 SHALL have ports:
 PCLK  in  1  clock, all logic on rising edge
 PRESETn  in  1  asynchronous, active-low reset
 AWVALID, AWREADY  in  1  write-address handshake
 AWADDR  in  ADDR_W  write address
 AWID  in  ID_W  write ID
 AWLEN  in  8  write beats minus one
 WVALID, WREADY, WLAST  in  1  write-data handshake, last beat
 BVALID, BREADY  in  1  write-response handshake
 ARVALID, ARREADY  in  1  read-address handshake
 ARADDR  in  ADDR_W  read address
 ARID  in  ID_W  read ID
 ARLEN  in  8  read beats minus one
 RVALID, RREADY, RLAST  in  1  read-data handshake, last beat
 clr  in  1  synchronous clear of sticky errors
 err_vec  out  8  sticky error flags
 err_pulse  out  1  one-cycle pulse, any new error bit
 err_first  out  3  index of first error since clear
 wr_outstanding  out  clog2(MAX_OUTSTANDING+1)+1  writes accepted, B not yet received
 rd_outstanding  out  clog2(MAX_OUTSTANDING+1)  reads accepted, RLAST not yet received

Function
REQ-006 Handshake on channel X SHALL be XVALID&XREADY sampled at PCLK rising edge.
REQ-007 err_vec[0] SHALL set when AWVALID&!AWREADY in cycle n and, in cycle n+1, AWVALID=0 or AWADDR/AWID/AWLEN changed.
REQ-008 err_vec[1] SHALL set on the same rule for W (WVALID, WLAST).
REQ-009 err_vec[2] SHALL set on the same rule for AR (ARVALID, ARADDR, ARID, ARLEN).
REQ-010 Each AW handshake SHALL push AWLEN into a write queue; each AR handshake SHALL push ARLEN into a read queue; completion is in order, IDs are not used for ordering.
REQ-011 W beats SHALL be counted against the write-queue head; err_vec[3] SHALL set when WLAST=1 with beat count != head+1, or WLAST=0 at beat head+1; the queue SHALL pop on the WLAST handshake regardless.
REQ-012 err_vec[4] SHALL apply the REQ-011 rule to R/RLAST against the read-queue head.
REQ-013 err_vec[5] (orphan) SHALL set on: W handshake with write queue empty; R handshake with read queue empty; B handshake with pending-B counter zero (a WLAST pop in the same cycle does not count).
REQ-014 err_vec[6] SHALL set on an AW or AR handshake while the matching queue is full; the push SHALL be dropped and the count unchanged.
REQ-015 err_vec[7] SHALL set when any of the five VALIDs stays high without READY for TIMEOUT_CYCLES consecutive cycles; the per-channel counter SHALL saturate, flag once per stall, and reset on handshake or VALID low.
REQ-016 Simultaneous push and pop on one queue SHALL leave its count unchanged; a WLAST pop with a B handshake in the same cycle SHALL leave pending-B unchanged.
REQ-017 wr_outstanding SHALL equal write-queue count + pending-B; rd_outstanding SHALL equal read-queue count.
REQ-018 Errors SHALL register one cycle after the violating edge; err_pulse SHALL be high for exactly that cycle if any previously clear bit sets.
REQ-019 err_first SHALL latch the lowest newly set index when err_vec was all zero; later errors SHALL not change it.
REQ-020 clr SHALL zero err_vec and err_first next cycle; an error detected in the clr cycle SHALL win and be recorded.

Reset
REQ-021 PRESETn low SHALL immediately zero err_vec, err_pulse, err_first, both queues, pending-B, beat and timeout counters, and stability history.
REQ-022 Reset mid-burst SHALL discard all tracking; the first post-reset cycle SHALL do no stability comparison.

Structure
REQ-023 Error index constants (ERR_AW_STAB..ERR_TIMEOUT) and the length typedef SHALL live in package axi_chk_pkg.
REQ-024 Both queues SHALL be instances of one sub-module axi_chk_fifo (width 8, depth MAX_OUTSTANDING, count output, async active-low reset).

Verification
REQ-025 AW AWLEN=3, four W beats with WLAST on beat 4, B -> err_vec=0, wr_outstanding 1->1->0.
REQ-026 AWVALID high, AWREADY low, AWADDR 0x100->0x104 next cycle -> err_vec[0]=1, err_first=0, err_pulse one cycle.
REQ-027 AR ARLEN=1, RLAST on first beat -> err_vec[4]=1; read queue pops, rd_outstanding=0.
REQ-028 Nine AR handshakes without R (MAX_OUTSTANDING=8) -> err_vec[6]=1 on the ninth, rd_outstanding=8.
REQ-029 ARVALID high, ARREADY low for 16 cycles -> err_vec[7]=1 once; clr with no new error -> err_vec=0.
REQ-030 PRESETn low during W beat 2 of a 4-beat burst -> all outputs 0; a new burst after reset passes clean.

Source files
------------

// File: rtl/axi_chk_pkg.sv
// Shared definitions for the AXI protocol checker: error bit indices,
// the burst length type held in the per-direction queues, and a helper
// that picks the lowest set error index.
package axi_chk_pkg;

  localparam int NUM_ERR      = 8;
  localparam int ERR_AW_STAB  = 0;  // AW payload changed / VALID dropped while stalled
  localparam int ERR_W_STAB   = 1;  // W payload changed / VALID dropped while stalled
  localparam int ERR_AR_STAB  = 2;  // AR payload changed / VALID dropped while stalled
  localparam int ERR_W_LEN    = 3;  // WLAST not on the beat AWLEN predicts
  localparam int ERR_R_LEN    = 4;  // RLAST not on the beat ARLEN predicts
  localparam int ERR_ORPHAN   = 5;  // data or response with nothing outstanding
  localparam int ERR_OVERFLOW = 6;  // address accepted while the queue is full
  localparam int ERR_TIMEOUT  = 7;  // VALID stalled too long on some channel

  // Burst length as carried on AxLEN (beats minus one).
  typedef logic [7:0] axi_len_t;

  // Index of the lowest set bit; 0 when nothing is set.
  function automatic logic [2:0] lowest_set(input logic [NUM_ERR-1:0] v);
    lowest_set = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/axi_chk_fifo.sv
// Small in-order FIFO holding burst lengths. A push while full and a pop
// while empty are ignored; the owner flags those cases itself.
module axi_chk_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign data_o  = mem[rd_ptr_q];
  assign count_o = count_q;

  // Occupancy: a simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointers and count; depth is a power of two so pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/axi_protocol_checker.sv
// Passive AXI protocol checker. Watches the five channels and records
// sticky error flags for payload stability, burst length, orphan
// transfers, queue overflow and stall timeouts. Handshake on any channel
// is VALID & READY sampled on the rising PCLK edge; the checker never
// drives the bus.
module axi_protocol_checker
  import axi_chk_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int ID_W            = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                                   PCLK,
  input  logic                                   PRESETn,
  input  logic                                   AWVALID,
  input  logic                                   AWREADY,
  input  logic [ADDR_W-1:0]                      AWADDR,
  input  logic [ID_W-1:0]                        AWID,
  input  logic [7:0]                             AWLEN,
  input  logic                                   WVALID,
  input  logic                                   WREADY,
  input  logic                                   WLAST,
  input  logic                                   BVALID,
  input  logic                                   BREADY,
  input  logic                                   ARVALID,
  input  logic                                   ARREADY,
  input  logic [ADDR_W-1:0]                      ARADDR,
  input  logic [ID_W-1:0]                        ARID,
  input  logic [7:0]                             ARLEN,
  input  logic                                   RVALID,
  input  logic                                   RREADY,
  input  logic                                   RLAST,
  input  logic                                   clr,
  output logic [7:0]                             err_vec,
  output logic                                   err_pulse,
  output logic [2:0]                             err_first,
  output logic [$clog2(MAX_OUTSTANDING+1):0]     wr_outstanding,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   rd_outstanding
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int WR_W  = CNT_W + 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] PEND_MX = CNT_W'(MAX_OUTSTANDING);

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  assign aw_hs = AWVALID & AWREADY;
  assign w_hs  = WVALID & WREADY;
  assign b_hs  = BVALID & BREADY;
  assign ar_hs = ARVALID & ARREADY;
  assign r_hs  = RVALID & RREADY;

  // ---- burst length queues -------------------------------------------
  axi_len_t         w_head, r_head;
  logic             wq_full, wq_empty, rq_full, rq_empty;
  logic [CNT_W-1:0] wq_count, rq_count;

  axi_chk_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_wq (
    .clk_i (PCLK), .rst_ni (PRESETn),
    .push_i (aw_hs), .pop_i (w_hs & WLAST), .data_i (AWLEN),
    .data_o (w_head), .full_o (wq_full), .empty_o (wq_empty), .count_o (wq_count)
  );

  axi_chk_fifo #(.WIDTH(8), .DEPTH(MAX_OUTSTANDING)) u_rq (
    .clk_i (PCLK), .rst_ni (PRESETn),
    .push_i (ar_hs), .pop_i (r_hs & RLAST), .data_i (ARLEN),
    .data_o (r_head), .full_o (rq_full), .empty_o (rq_empty), .count_o (rq_count)
  );

  // ---- state ----------------------------------------------------------
  logic              aw_stall_q, w_stall_q, ar_stall_q;
  logic [ADDR_W-1:0] aw_addr_q, ar_addr_q;
  logic [ID_W-1:0]   aw_id_q, ar_id_q;
  axi_len_t          aw_len_q, ar_len_q;
  logic              w_last_q;

  logic [8:0]        w_beat_q, w_beat_d, r_beat_q, r_beat_d;
  logic [8:0]        w_beat_num, r_beat_num, w_exp, r_exp;
  logic [CNT_W-1:0]  pend_q, pend_d;
  logic [TO_W-1:0]   to_q [5];
  logic [TO_W-1:0]   to_d [5];
  logic [4:0]        ch_stall, to_hit;

  logic [7:0]        det, new_bits;
  logic [7:0]        err_vec_q, err_vec_d;
  logic [2:0]        err_first_q, err_first_d;
  logic              err_pulse_q;
  logic              wlast_pop, b_ok;

  // Beat numbers are 1-based and saturate so a runaway burst never wraps
  // back onto a matching length.
  assign w_beat_num = (w_beat_q == '1) ? w_beat_q : w_beat_q + 9'd1;
  assign r_beat_num = (r_beat_q == '1) ? r_beat_q : r_beat_q + 9'd1;
  assign w_exp      = {1'b0, w_head} + 9'd1;
  assign r_exp      = {1'b0, r_head} + 9'd1;
  assign wlast_pop  = w_hs & WLAST & ~wq_empty;
  assign b_ok       = b_hs & (pend_q != '0);

  assign ch_stall = {RVALID & ~RREADY, ARVALID & ~ARREADY, BVALID & ~BREADY,
                     WVALID & ~WREADY, AWVALID & ~AWREADY};

  // Stall counters: count while stalled, saturate at the limit so each
  // stall flags only once, clear on handshake or VALID low.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      to_d[i]   = '0;
      to_hit[i] = 1'b0;
      if (ch_stall[i]) begin
        to_d[i]   = (to_q[i] == TO_MAX) ? to_q[i] : to_q[i] + TO_W'(1);
        to_hit[i] = (to_q[i] == TO_MAX - TO_W'(1));
      end
    end
  end

  // Violation detection for this edge plus next beat and pending-B values.
  always_comb begin
    det      = '0;
    w_beat_d = w_beat_q;
    r_beat_d = r_beat_q;
    pend_d   = pend_q;

    det[ERR_AW_STAB] = aw_stall_q & (~AWVALID | (AWADDR != aw_addr_q) |
                                     (AWID != aw_id_q) | (AWLEN != aw_len_q));
    det[ERR_W_STAB]  = w_stall_q & (~WVALID | (WLAST != w_last_q));
    det[ERR_AR_STAB] = ar_stall_q & (~ARVALID | (ARADDR != ar_addr_q) |
                                     (ARID != ar_id_q) | (ARLEN != ar_len_q));

    if (w_hs) begin
      if (wq_empty) begin
        det[ERR_ORPHAN] = 1'b1;
      end else begin
        if (WLAST != (w_beat_num == w_exp)) det[ERR_W_LEN] = 1'b1;
        w_beat_d = WLAST ? 9'd0 : w_beat_num;
      end
    end

    if (r_hs) begin
      if (rq_empty) begin
        det[ERR_ORPHAN] = 1'b1;
      end else begin
        if (RLAST != (r_beat_num == r_exp)) det[ERR_R_LEN] = 1'b1;
        r_beat_d = RLAST ? 9'd0 : r_beat_num;
      end
    end

    // B is judged against pending-B before this edge's WLAST pop lands.
    if (b_hs && pend_q == '0) det[ERR_ORPHAN] = 1'b1;

    // Pending-B saturates at the queue depth so the sum always fits.
    case ({wlast_pop, b_ok})
      2'b10:   pend_d = (pend_q == PEND_MX) ? pend_q : pend_q + CNT_W'(1);
      2'b01:   pend_d = pend_q - CNT_W'(1);
      default: pend_d = pend_q;
    endcase

    det[ERR_OVERFLOW] = (aw_hs & wq_full) | (ar_hs & rq_full);
    det[ERR_TIMEOUT]  = |to_hit;
  end

  // Sticky error state: clr wipes old flags but keeps anything found now.
  always_comb begin
    new_bits    = det & (clr ? 8'hFF : ~err_vec_q);
    err_vec_d   = clr ? det : (err_vec_q | det);
    err_first_d = err_first_q;
    if (clr) begin
      err_first_d = (|det) ? lowest_set(det) : 3'd0;
    end else if (err_vec_q == '0 && (|det)) begin
      err_first_d = lowest_set(det);
    end
  end

  // Stability history: remember each stalled payload for the next edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      aw_stall_q <= 1'b0;
      w_stall_q  <= 1'b0;
      ar_stall_q <= 1'b0;
      aw_addr_q  <= '0;
      aw_id_q    <= '0;
      aw_len_q   <= '0;
      w_last_q   <= 1'b0;
      ar_addr_q  <= '0;
      ar_id_q    <= '0;
      ar_len_q   <= '0;
    end else begin
      aw_stall_q <= AWVALID & ~AWREADY;
      w_stall_q  <= WVALID & ~WREADY;
      ar_stall_q <= ARVALID & ~ARREADY;
      aw_addr_q  <= AWADDR;
      aw_id_q    <= AWID;
      aw_len_q   <= AWLEN;
      w_last_q   <= WLAST;
      ar_addr_q  <= ARADDR;
      ar_id_q    <= ARID;
      ar_len_q   <= ARLEN;
    end
  end

  // Burst tracking: beat counters, pending-B and stall counters.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      w_beat_q <= '0;
      r_beat_q <= '0;
      pend_q   <= '0;
      for (int i = 0; i < 5; i++) to_q[i] <= '0;
    end else begin
      w_beat_q <= w_beat_d;
      r_beat_q <= r_beat_d;
      pend_q   <= pend_d;
      for (int i = 0; i < 5; i++) to_q[i] <= to_d[i];
    end
  end

  // Registered error outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_vec_q   <= '0;
      err_first_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      err_vec_q   <= err_vec_d;
      err_first_q <= err_first_d;
      err_pulse_q <= |new_bits;
    end
  end

  assign err_vec        = err_vec_q;
  assign err_first      = err_first_q;
  assign err_pulse      = err_pulse_q;
  assign wr_outstanding = WR_W'(wq_count) + WR_W'(pend_q);
  assign rd_outstanding = rq_count;

endmodule

// File: tb/tb_axi_protocol_checker.sv
// Directed bench for axi_protocol_checker with a queue-based reference
// model compared on every falling edge, plus literal spot checks.
module tb_axi_protocol_checker;

  localparam int ADDR_W = 32;
  localparam int ID_W   = 4;
  localparam int MAXO   = 8;
  localparam int TO     = 16;

  // ---- clock / reset ---------------------------------------------------
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  logic              AWVALID, AWREADY, WVALID, WREADY, WLAST, BVALID, BREADY;
  logic              ARVALID, ARREADY, RVALID, RREADY, RLAST, clr;
  logic [ADDR_W-1:0] AWADDR, ARADDR;
  logic [ID_W-1:0]   AWID, ARID;
  logic [7:0]        AWLEN, ARLEN;
  logic [7:0]        err_vec;
  logic              err_pulse;
  logic [2:0]        err_first;
  logic [4:0]        wr_outstanding;
  logic [3:0]        rd_outstanding;

  int checks = 0;
  int errors = 0;

  axi_protocol_checker #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN),
    .WVALID(WVALID), .WREADY(WREADY), .WLAST(WLAST),
    .BVALID(BVALID), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN),
    .RVALID(RVALID), .RREADY(RREADY), .RLAST(RLAST),
    .clr(clr), .err_vec(err_vec), .err_pulse(err_pulse), .err_first(err_first),
    .wr_outstanding(wr_outstanding), .rd_outstanding(rd_outstanding)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- reference model -------------------------------------------------
  logic [7:0]        m_wq[$];
  logic [7:0]        m_rq[$];
  int                m_pend = 0, m_wbeat = 0, m_rbeat = 0;
  int                m_to[5];
  logic              m_aw_st = 0, m_w_st = 0, m_ar_st = 0, m_w_last = 0;
  logic [ADDR_W-1:0] m_aw_addr = '0, m_ar_addr = '0;
  logic [ID_W-1:0]   m_aw_id = '0, m_ar_id = '0;
  logic [7:0]        m_aw_len = '0, m_ar_len = '0;
  logic [7:0]        m_ev = 8'h00;
  logic              m_pulse = 1'b0;
  logic [2:0]        m_first = 3'd0;
  logic [7:0]        det, newb;
  logic              aw_full, ar_full, wlast_pop;
  logic [4:0]        stall;

  function automatic logic [2:0] lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      m_wq.delete(); m_rq.delete();
      m_pend = 0; m_wbeat = 0; m_rbeat = 0;
      for (int i = 0; i < 5; i++) m_to[i] = 0;
      m_aw_st = 0; m_w_st = 0; m_ar_st = 0;
      m_ev = 8'h00; m_pulse = 1'b0; m_first = 3'd0;
    end else begin
      det = 8'h00;
      if (m_aw_st && (!AWVALID || AWADDR !== m_aw_addr || AWID !== m_aw_id || AWLEN !== m_aw_len)) det[0] = 1;
      if (m_w_st && (!WVALID || WLAST !== m_w_last)) det[1] = 1;
      if (m_ar_st && (!ARVALID || ARADDR !== m_ar_addr || ARID !== m_ar_id || ARLEN !== m_ar_len)) det[2] = 1;
      m_aw_st = AWVALID && !AWREADY; m_aw_addr = AWADDR; m_aw_id = AWID; m_aw_len = AWLEN;
      m_w_st  = WVALID && !WREADY;   m_w_last = WLAST;
      m_ar_st = ARVALID && !ARREADY; m_ar_addr = ARADDR; m_ar_id = ARID; m_ar_len = ARLEN;

      aw_full = (m_wq.size() == MAXO);
      ar_full = (m_rq.size() == MAXO);
      wlast_pop = 0;
      if (WVALID && WREADY) begin
        if (m_wq.size() == 0) det[5] = 1;
        else begin
          m_wbeat++;
          if (WLAST && m_wbeat != int'(m_wq[0]) + 1) det[3] = 1;
          if (!WLAST && m_wbeat == int'(m_wq[0]) + 1) det[3] = 1;
          if (WLAST) begin void'(m_wq.pop_front()); m_wbeat = 0; wlast_pop = 1; end
        end
      end
      if (RVALID && RREADY) begin
        if (m_rq.size() == 0) det[5] = 1;
        else begin
          m_rbeat++;
          if (RLAST && m_rbeat != int'(m_rq[0]) + 1) det[4] = 1;
          if (!RLAST && m_rbeat == int'(m_rq[0]) + 1) det[4] = 1;
          if (RLAST) begin void'(m_rq.pop_front()); m_rbeat = 0; end
        end
      end
      if (BVALID && BREADY) begin
        if (m_pend == 0) det[5] = 1;
        else m_pend--;
      end
      if (wlast_pop && m_pend < MAXO) m_pend++;
      if (AWVALID && AWREADY) begin
        if (aw_full) det[6] = 1; else m_wq.push_back(AWLEN);
      end
      if (ARVALID && ARREADY) begin
        if (ar_full) det[6] = 1; else m_rq.push_back(ARLEN);
      end

      stall = {RVALID && !RREADY, ARVALID && !ARREADY, BVALID && !BREADY,
               WVALID && !WREADY, AWVALID && !AWREADY};
      for (int i = 0; i < 5; i++) begin
        if (stall[i]) begin
          if (m_to[i] < TO) begin
            m_to[i]++;
            if (m_to[i] == TO) det[7] = 1;
          end
        end else m_to[i] = 0;
      end

      newb = det & (clr ? 8'hFF : ~m_ev);
      m_pulse = (newb != 0);
      if (clr) begin
        m_ev = det;
        m_first = (det != 0) ? lowest(det) : 3'd0;
      end else begin
        if (m_ev == 0 && det != 0) m_first = lowest(det);
        m_ev = m_ev | det;
      end
    end
  end

  // Single compare process against the model on every falling edge.
  always @(negedge PCLK) begin
    chk("model_err_vec",   32'(err_vec),   32'(m_ev));
    chk("model_err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("model_err_first", 32'(err_first), 32'(m_first));
    chk("model_wr_out",    32'(wr_outstanding), 32'(m_wq.size() + m_pend));
    chk("model_rd_out",    32'(rd_outstanding), 32'(m_rq.size()));
  end

  // ---- driver tasks ----------------------------------------------------
  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic idle();
    AWVALID = 0; AWREADY = 0; AWADDR = '0; AWID = '0; AWLEN = '0;
    WVALID = 0; WREADY = 0; WLAST = 0; BVALID = 0; BREADY = 0;
    ARVALID = 0; ARREADY = 0; ARADDR = '0; ARID = '0; ARLEN = '0;
    RVALID = 0; RREADY = 0; RLAST = 0; clr = 0;
  endtask

  task automatic aw_hs(input logic [7:0] len);
    AWVALID = 1; AWREADY = 1; AWLEN = len; AWADDR = 32'h1000; AWID = 4'h1;
    tick();
    AWVALID = 0; AWREADY = 0;
  endtask

  task automatic ar_hs(input logic [7:0] len);
    ARVALID = 1; ARREADY = 1; ARLEN = len; ARADDR = 32'h2000; ARID = 4'h2;
    tick();
    ARVALID = 0; ARREADY = 0;
  endtask

  task automatic do_clr();
    clr = 1; tick(); clr = 0;
  endtask

  // ---- stimulus ----------------------------------------------------------
  initial begin
    idle();
    repeat (3) @(posedge PCLK);
    #2;
    chk("reset_err_vec", 32'(err_vec), 32'h0);
    chk("reset_wr_out", 32'(wr_outstanding), 32'h0);
    PRESETn = 1;
    tick();

    // Clean 4-beat write burst.
    aw_hs(8'd3);
    chk("t1_wr_out_aw", 32'(wr_outstanding), 32'd1);
    WVALID = 1; WREADY = 1; WLAST = 0;
    repeat (3) tick();
    WLAST = 1; tick();
    WVALID = 0; WREADY = 0; WLAST = 0;
    chk("t1_wr_out_wlast", 32'(wr_outstanding), 32'd1);
    BVALID = 1; BREADY = 1; tick(); BVALID = 0; BREADY = 0;
    chk("t1_wr_out_b", 32'(wr_outstanding), 32'd0);
    chk("t1_err_vec", 32'(err_vec), 32'h0);

    // AWADDR changes while stalled.
    AWVALID = 1; AWREADY = 0; AWADDR = 32'h100; AWLEN = 8'd0; AWID = 4'h3;
    tick();
    chk("t2_err_before", 32'(err_vec), 32'h0);
    AWADDR = 32'h104; tick();
    chk("t2_err_vec", 32'(err_vec), 32'h01);
    chk("t2_err_first", 32'(err_first), 32'd0);
    chk("t2_pulse_hi", 32'(err_pulse), 32'd1);
    AWREADY = 1; tick(); AWVALID = 0; AWREADY = 0;
    chk("t2_pulse_lo", 32'(err_pulse), 32'd0);
    WVALID = 1; WREADY = 1; WLAST = 1; tick(); WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 1; BREADY = 1; tick(); BVALID = 0; BREADY = 0;
    do_clr();
    chk("t2_clr_err", 32'(err_vec), 32'h0);

    // Early RLAST on a 2-beat read.
    ar_hs(8'd1);
    chk("t3_rd_out_ar", 32'(rd_outstanding), 32'd1);
    RVALID = 1; RREADY = 1; RLAST = 1; tick(); RVALID = 0; RREADY = 0; RLAST = 0;
    chk("t3_err_vec", 32'(err_vec), 32'h10);
    chk("t3_err_first", 32'(err_first), 32'd4);
    chk("t3_rd_out", 32'(rd_outstanding), 32'd0);
    do_clr();

    // Nine reads into an eight-deep queue.
    ARVALID = 1; ARREADY = 1; ARLEN = 8'd0; ARADDR = 32'h3000;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i == 7) chk("t4_err_at8", 32'(err_vec), 32'h0);
    end
    ARVALID = 0; ARREADY = 0;
    chk("t4_err_vec", 32'(err_vec), 32'h40);
    chk("t4_rd_out", 32'(rd_outstanding), 32'd8);
    RVALID = 1; RREADY = 1; RLAST = 1;
    repeat (8) tick();
    RVALID = 0; RREADY = 0; RLAST = 0;
    chk("t4_rd_drained", 32'(rd_outstanding), 32'd0);
    do_clr();

    // AR stall timeout.
    ARVALID = 1; ARREADY = 0; ARADDR = 32'h200; ARLEN = 8'd0;
    repeat (15) tick();
    chk("t5_err_15", 32'(err_vec), 32'h0);
    tick();
    chk("t5_err_16", 32'(err_vec), 32'h80);
    chk("t5_pulse", 32'(err_pulse), 32'd1);
    chk("t5_first", 32'(err_first), 32'd7);
    repeat (4) tick();
    chk("t5_pulse_once", 32'(err_pulse), 32'd0);
    ARREADY = 1; tick(); ARVALID = 0; ARREADY = 0;
    chk("t5_rd_out", 32'(rd_outstanding), 32'd1);
    do_clr();
    chk("t5_clr_err", 32'(err_vec), 32'h0);
    RVALID = 1; RREADY = 1; RLAST = 1; tick(); RVALID = 0; RREADY = 0; RLAST = 0;
    chk("t5_clean", 32'(err_vec), 32'h0);

    // Orphan B, W stability, error landing in a clr cycle.
    BVALID = 1; BREADY = 1; tick(); BVALID = 0; BREADY = 0;
    chk("t6_orphan", 32'(err_vec), 32'h20);
    chk("t6_orphan_first", 32'(err_first), 32'd5);
    do_clr();
    aw_hs(8'd1);
    WVALID = 1; WREADY = 0; WLAST = 0; tick();
    WLAST = 1; tick();
    chk("t6_wstab", 32'(err_vec), 32'h02);
    chk("t6_wstab_first", 32'(err_first), 32'd1);
    WLAST = 0; WREADY = 1; tick();
    chk("t6_no_repulse", 32'(err_pulse), 32'd0);
    WLAST = 1; tick(); WVALID = 0; WREADY = 0; WLAST = 0;
    chk("t6_wr_out", 32'(wr_outstanding), 32'd1);
    BVALID = 1; BREADY = 1; tick();
    clr = 1; tick(); clr = 0; BVALID = 0; BREADY = 0;
    chk("t6_clr_wins_err", 32'(err_vec), 32'h20);
    chk("t6_clr_wins_first", 32'(err_first), 32'd5);
    do_clr();

    // WLAST pop and B in the same cycle.
    AWVALID = 1; AWREADY = 1; AWLEN = 8'd0; tick(); tick(); AWVALID = 0; AWREADY = 0;
    chk("t7_wr_out2", 32'(wr_outstanding), 32'd2);
    WVALID = 1; WREADY = 1; WLAST = 1; tick();
    BVALID = 1; BREADY = 1; tick();
    WVALID = 0; WREADY = 0; WLAST = 0;
    chk("t7_wr_out_same", 32'(wr_outstanding), 32'd1);
    tick(); BVALID = 0; BREADY = 0;
    chk("t7_wr_out0", 32'(wr_outstanding), 32'd0);
    chk("t7_err", 32'(err_vec), 32'h0);

    // Reset in the middle of a write burst.
    RVALID = 1; RREADY = 1; RLAST = 1; tick(); RVALID = 0; RREADY = 0; RLAST = 0;
    ar_hs(8'd0);
    aw_hs(8'd3);
    WVALID = 1; WREADY = 1; WLAST = 0; tick();
    chk("t8_pre_err", 32'(err_vec), 32'h20);
    chk("t8_pre_rd", 32'(rd_outstanding), 32'd1);
    #1 PRESETn = 0;
    #1;
    idle();
    chk("t8_rst_err", 32'(err_vec), 32'h0);
    chk("t8_rst_first", 32'(err_first), 32'd0);
    chk("t8_rst_pulse", 32'(err_pulse), 32'd0);
    chk("t8_rst_wr", 32'(wr_outstanding), 32'd0);
    chk("t8_rst_rd", 32'(rd_outstanding), 32'd0);
    tick(); tick();
    PRESETn = 1;
    tick();
    aw_hs(8'd1);
    WVALID = 1; WREADY = 1; WLAST = 0; tick();
    WLAST = 1; tick(); WVALID = 0; WREADY = 0; WLAST = 0;
    BVALID = 1; BREADY = 1; tick(); BVALID = 0; BREADY = 0;
    chk("t8_post_err", 32'(err_vec), 32'h0);
    chk("t8_post_wr", 32'(wr_outstanding), 32'd0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
